// File: rtl/i2s_pkg.sv
// i2s_pkg -- shared types, constants and helpers for the stereo I2S transmitter.
//
// Contents:
//   MAX_SLOT_WIDTH  widest channel slot the helpers handle
//   LR_LEFT/RIGHT   word-select levels (0 = left channel, 1 = right channel)
//   slot_t          one channel slot at maximum width; users keep the low
//                   SLOT_WIDTH bits
//   frame_t         {left slot, right slot}; the left slot is sent first
//   pad_slot()      places a sample left-justified in a slot and zero-fills
//                   the bits below it

package i2s_pkg;

    localparam int MAX_SLOT_WIDTH = 64;

    localparam logic LR_LEFT  = 1'b0;
    localparam logic LR_RIGHT = 1'b1;

    typedef logic [MAX_SLOT_WIDTH-1:0] slot_t;

    typedef struct packed {
        slot_t left;
        slot_t right;
    } frame_t;

    // The result holds the padded slot in its low slot_w bits. The sample
    // occupies the top sample_w of those bits and the rest are zero.
    function automatic slot_t pad_slot(input slot_t sample,
                                       input int    sample_w,
                                       input int    slot_w);
        slot_t mask;
        mask = (slot_t'(1) << sample_w) - slot_t'(1);
        return (sample & mask) << (slot_w - sample_w);
    endfunction

endpackage

// File: rtl/i2s_stereo_tx_clk_div.sv
// i2s_clk_div -- bit-clock generator for the I2S transmitter.
//
// A counter runs from 0 to CLKDIV-1. Each time it wraps, bclk toggles, so one
// BCLK period lasts 2*CLKDIV system clocks. fall_o is high during the cycle
// whose closing edge takes bclk from 1 to 0. Serial state that updates on
// that same edge stays aligned with the falling edge of BCLK.
//
// Ports:
//   clk_i    system clock
//   reset_i  synchronous active-high reset (div 0, bclk 0)
//   bclk_o   bit clock
//   fall_o   strobe: bclk falls at the end of this cycle

module i2s_clk_div #(
    parameter int CLKDIV = 4
) (
    input  logic clk_i,
    input  logic reset_i,
    output logic bclk_o,
    output logic fall_o
);

    localparam int DW = (CLKDIV > 1) ? $clog2(CLKDIV) : 1;

    logic [DW-1:0] div_q, div_d;
    logic          bclk_q, bclk_d;
    logic          wrap;

    assign wrap = (div_q == DW'(CLKDIV - 1));

    always_comb begin
        div_d  = div_q + DW'(1);
        bclk_d = bclk_q;
        if (wrap) begin
            div_d  = '0;
            bclk_d = ~bclk_q;
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            div_q  <= '0;
            bclk_q <= 1'b0;
        end else begin
            div_q  <= div_d;
            bclk_q <= bclk_d;
        end
    end

    assign bclk_o = bclk_q;
    assign fall_o = wrap && bclk_q;

endmodule

// File: rtl/i2s_stereo_tx.sv
// i2s_stereo_tx -- stereo I2S (Philips framing) transmitter.
//
// Serialises left/right sample pairs MSB first. Each channel slot is
// SLOT_WIDTH bits long, with the sample left-justified in it. Data lags
// each LRCLK edge by one BCLK. An incoming pair waits in a one-deep holding
// register until the next frame boundary. A frame boundary that finds the
// holding register empty raises a one-cycle underrun pulse and sends a
// substitute frame instead.
//
// Build option:
//   I2S_TX_REPEAT_ON_UNDERRUN_EN  substitute frame = last loaded frame
//                                 (zeros if none since reset);
//                                 otherwise the substitute frame is zeros.
//
// Parameters:
//   SAMPLE_WIDTH  bits per channel sample (8..32)
//   SLOT_WIDTH    BCLK periods per channel slot (>= SAMPLE_WIDTH)
//   CLKDIV        system clocks per BCLK half-period (>= 1)
//
// Ports:
//   clk           system clock
//   reset         synchronous active-high reset
//   sample_left   left sample (two's complement), captured on accept
//   sample_right  right sample, captured on accept
//   sample_valid  pair offered
//   sample_ready  holding register empty; accept = valid && ready
//   bclk          bit clock, period 2*CLKDIV clk
//   lrclk         word select, 0 = left, 1 = right
//   sdata         serial data, changes on BCLK falling edges
//   underrun      one-cycle pulse: frame started with holding register empty

module i2s_stereo_tx
    import i2s_pkg::*;
#(
    parameter int SAMPLE_WIDTH = 16,
    parameter int SLOT_WIDTH   = 16,
    parameter int CLKDIV       = 4
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [SAMPLE_WIDTH-1:0] sample_left,
    input  logic [SAMPLE_WIDTH-1:0] sample_right,
    input  logic                    sample_valid,
    output logic                    sample_ready,
    output logic                    bclk,
    output logic                    lrclk,
    output logic                    sdata,
    output logic                    underrun
);

    localparam int FW  = 2 * SLOT_WIDTH;
    localparam int BCW = $clog2(FW);

    logic fall;

    i2s_clk_div #(
        .CLKDIV (CLKDIV)
    ) u_clk_div (
        .clk_i   (clk),
        .reset_i (reset),
        .bclk_o  (bclk),
        .fall_o  (fall)
    );

    logic [BCW-1:0] bc_q, bc_d, bc_n;
    logic           lrclk_q, lrclk_d;
    logic           sdata_q, sdata_d;
    logic           underrun_q, underrun_d;
    logic           full_q, full_d;
    logic [FW-1:0]  hold_q, hold_d;
    logic [FW-1:0]  shreg_q, shreg_d;
    logic [FW-1:0]  new_frame, sub_frame, load_frame;
    logic           accept, load;

    // The incoming pair is padded into frame layout at accept time, so the
    // load path is a plain register copy.
    assign new_frame = {
        SLOT_WIDTH'(pad_slot(slot_t'(sample_left),  SAMPLE_WIDTH, SLOT_WIDTH)),
        SLOT_WIDTH'(pad_slot(slot_t'(sample_right), SAMPLE_WIDTH, SLOT_WIDTH))
    };

`ifdef I2S_TX_REPEAT_ON_UNDERRUN_EN
    logic [FW-1:0] last_q, last_d;
    assign sub_frame = last_q;
`else
    assign sub_frame = '0;
`endif

    // bc_n is the bit count that takes effect at this fall event. Frame bit
    // (bc_n-1) goes out now, so the frame loads when bc_n == 1. Bit 0 then
    // appears one BCLK after lrclk fell at bc_n == 0.
    assign bc_n   = (bc_q == BCW'(FW - 1)) ? '0 : bc_q + BCW'(1);
    assign load   = fall && (bc_n == BCW'(1));
    assign accept = sample_valid && !full_q;

    always_comb begin
        bc_d       = bc_q;
        lrclk_d    = lrclk_q;
        sdata_d    = sdata_q;
        shreg_d    = shreg_q;
        full_d     = full_q;
        hold_d     = hold_q;
        underrun_d = 1'b0;
        load_frame = full_q ? hold_q : sub_frame;
`ifdef I2S_TX_REPEAT_ON_UNDERRUN_EN
        last_d     = last_q;
`endif

        if (fall) begin
            bc_d    = bc_n;
            lrclk_d = (bc_n >= BCW'(SLOT_WIDTH)) ? LR_RIGHT : LR_LEFT;
            if (load) begin
                sdata_d    = load_frame[FW-1];
                shreg_d    = {load_frame[FW-2:0], 1'b0};
                full_d     = 1'b0;
                underrun_d = !full_q;
`ifdef I2S_TX_REPEAT_ON_UNDERRUN_EN
                last_d     = load_frame;
`endif
            end else begin
                sdata_d = shreg_q[FW-1];
                shreg_d = {shreg_q[FW-2:0], 1'b0};
            end
        end

        // This comes after the load. A pair accepted in the load cycle (the
        // register was empty) fills the register for the next frame. It never
        // bypasses into the frame that is starting now.
        if (accept) begin
            full_d = 1'b1;
            hold_d = new_frame;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            bc_q       <= BCW'(FW - 1);
            lrclk_q    <= LR_LEFT;
            sdata_q    <= 1'b0;
            underrun_q <= 1'b0;
            full_q     <= 1'b0;
            hold_q     <= '0;
            shreg_q    <= '0;
`ifdef I2S_TX_REPEAT_ON_UNDERRUN_EN
            last_q     <= '0;
`endif
        end else begin
            bc_q       <= bc_d;
            lrclk_q    <= lrclk_d;
            sdata_q    <= sdata_d;
            underrun_q <= underrun_d;
            full_q     <= full_d;
            hold_q     <= hold_d;
            shreg_q    <= shreg_d;
`ifdef I2S_TX_REPEAT_ON_UNDERRUN_EN
            last_q     <= last_d;
`endif
        end
    end

    assign sample_ready = !full_q;
    assign lrclk        = lrclk_q;
    assign sdata        = sdata_q;
    assign underrun     = underrun_q;

endmodule

// File: tb/tb_i2s_stereo_tx.sv
// tb_i2s_stereo_tx -- directed bench for i2s_stereo_tx.
// u_dut:   SAMPLE 16, SLOT 16, CLKDIV 2. Frame = 128 clk; loads at t = 8 mod 128.
// u_dut24: SAMPLE 16, SLOT 24, CLKDIV 2. Frame = 192 clk; loads at t = 8 mod 192.
// t counts the rising edges since reset was released. Each check samples
// the DUT 1 time unit after an edge.

module tb_i2s_stereo_tx;

    logic        clk   = 1'b0;
    logic        reset = 1'b1;
    logic [15:0] sl = '0, sr = '0;
    logic        sv = 1'b0;
    logic        rdy, bclk, lrclk, sd, ur;
    logic [15:0] sl24 = '0, sr24 = '0;
    logic        sv24 = 1'b0;
    logic        rdy24, bclk24, lrclk24, sd24, ur24;

    int t = 0;
    int n_cmp = 0;
    int n_err = 0;

`ifdef I2S_TX_REPEAT_ON_UNDERRUN_EN
    localparam bit REP = 1'b1;
`else
    localparam bit REP = 1'b0;
`endif

    i2s_stereo_tx #(.SAMPLE_WIDTH(16), .SLOT_WIDTH(16), .CLKDIV(2)) u_dut (
        .clk(clk), .reset(reset), .sample_left(sl), .sample_right(sr),
        .sample_valid(sv), .sample_ready(rdy), .bclk(bclk), .lrclk(lrclk),
        .sdata(sd), .underrun(ur)
    );

    i2s_stereo_tx #(.SAMPLE_WIDTH(16), .SLOT_WIDTH(24), .CLKDIV(2)) u_dut24 (
        .clk(clk), .reset(reset), .sample_left(sl24), .sample_right(sr24),
        .sample_valid(sv24), .sample_ready(rdy24), .bclk(bclk24), .lrclk(lrclk24),
        .sdata(sd24), .underrun(ur24)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (reset) t <= 0;
        else       t <= t + 1;
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0d)", tag, got, exp, t);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Offers one pair to u_dut and returns once it has been accepted.
    // If keep is set, valid stays high so the caller can offer the next pair.
    task automatic feed(input logic [15:0] l, input logic [15:0] r, input bit keep);
        logic acc;
        acc = 1'b0;
        sv  = 1'b1;
        sl  = l;
        sr  = r;
        for (int k = 0; k < 400 && !acc; k++) begin
            acc = rdy;
            step();
        end
        if (!keep) sv = 1'b0;
        chk("feed_acc", acc, 1'b1);
    endtask

    // Waits for the next u_dut frame load and captures its 32 bits. Returns
    // at t = 7 mod 128, so a following grab gets the very next frame.
    task automatic grab(input string tag, input logic [31:0] exp_f,
                        input logic exp_ur, input logic exp_rb);
        logic [31:0] f;
        f = '0;
        for (int k = 0; k < 300 && (t % 128) != 7; k++) step();
        chk({tag, "_sync"}, 64'((t % 128) == 7), 64'd1);
        chk({tag, "_rdy_pre"}, rdy, exp_rb);
        step();
        chk({tag, "_ur"}, ur, exp_ur);
        for (int i = 0; i < 32; i++) begin
            f[31-i] = sd;
            if (i == 14) chk({tag, "_lr14"}, lrclk, 1'b0);
            if (i == 15) chk({tag, "_lr15"}, lrclk, 1'b1);
            if (i == 31) chk({tag, "_lr31"}, lrclk, 1'b0);
            repeat ((i < 31) ? 4 : 3) step();
        end
        chk({tag, "_data"}, f, exp_f);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        int eb, el, eu, es;
        bit exp_b, exp_l, exp_u;
        logic [47:0] f48;
        eb = 0; el = 0; eu = 0; es = 0;
        f48 = '0;

        // Reset values
        repeat (3) step();
        chk("rst_bclk", bclk, 1'b0);
        chk("rst_lrclk", lrclk, 1'b0);
        chk("rst_sdata", sd, 1'b0);
        chk("rst_ready", rdy, 1'b1);
        chk("rst_ur", ur, 1'b0);
        reset = 1'b0;

        // Idle with no samples: check the clock shapes and the underrun
        // cadence against closed-form expectations.
        for (int k = 0; k <= 136; k++) begin
            if (k > 0) step();
            exp_b = ((t / 2) % 2) == 1;
            exp_l = (t >= 4) && (((t / 4 - 1) % 32) >= 16);
            exp_u = (t >= 8) && ((t % 128) == 8);
            if (bclk !== exp_b) eb++;
            if (lrclk !== exp_l) el++;
            if (ur !== exp_u) eu++;
            if (sd !== 1'b0) es++;
            if (t == 8) chk("first_ur", ur, 1'b1);
        end
        chk("idle_t", t, 136);
        chk("idle_bclk", eb, 0);
        chk("idle_lrclk", el, 0);
        chk("idle_ur", eu, 0);
        chk("idle_sdata", es, 0);

        // Single pair, then starvation
        feed(16'hA5F0, 16'h0F0F, 1'b0);
        chk("b_rdy_low", rdy, 1'b0);
        grab("b_frame", 32'hA5F0_0F0F, 1'b0, 1'b0);
        grab("b_under", REP ? 32'hA5F0_0F0F : 32'h0, 1'b1, 1'b1);

        // Continuous valid. The first pair is accepted on a load edge, so
        // that frame is still an underrun and the pair goes out in the next one.
        fork
            begin
                feed(16'hAAAA, 16'h5555, 1'b1);
                feed(16'h5555, 16'hAAAA, 1'b1);
                feed(16'h1234, 16'h5678, 1'b0);
            end
            begin
                grab("c_bypass", REP ? 32'hA5F0_0F0F : 32'h0, 1'b1, 1'b1);
                grab("c_p1", 32'hAAAA_5555, 1'b0, 1'b0);
                grab("c_p2", 32'h5555_AAAA, 1'b0, 1'b0);
                grab("c_p3", 32'h1234_5678, 1'b0, 1'b0);
            end
        join
        grab("c_stop", REP ? 32'h1234_5678 : 32'h0, 1'b1, 1'b1);

        // Reset mid-frame at bc = 10 while a pair is held
        step();
        feed(16'hBEEF, 16'hCAFE, 1'b0);
        chk("d_held", rdy, 1'b0);
        for (int k = 0; k < 100 && t != 1198; k++) step();
        chk("d_sync", t, 1198);
        chk("d_bclk_pre", bclk, 1'b1);
        reset = 1'b1;
        step();
        chk("d_rst_bclk", bclk, 1'b0);
        chk("d_rst_lrclk", lrclk, 1'b0);
        chk("d_rst_sdata", sd, 1'b0);
        chk("d_rst_ready", rdy, 1'b1);
        chk("d_rst_ur", ur, 1'b0);
        reset = 1'b0;

        // Resume after reset; u_dut24 transmits L=0x8001 in a 24-bit slot
        sv24 = 1'b1;
        sl24 = 16'h8001;
        sr24 = 16'h0000;
        step();
        sv24 = 1'b0;
        chk("e24_rdy_low", rdy24, 1'b0);
        for (int k = 0; k < 400 && t < 200; k++) begin
            step();
            if (t == 2) chk("e_bclk_resume", bclk, 1'b1);
            if (t == 8) begin
                chk("e_discard_ur", ur, 1'b1);
                chk("e24_ur_first", ur24, 1'b0);
                chk("e24_rdy_after_load", rdy24, 1'b1);
            end
            if (t == 99)  chk("e24_lr99", lrclk24, 1'b0);
            if (t == 100) chk("e24_lr100", lrclk24, 1'b1);
            if (t >= 8 && t < 8 + 4 * 48 && ((t - 8) % 4) == 0)
                f48[47 - (t - 8) / 4] = sd24;
        end
        chk("e24_t", t, 200);
        chk("e24_frame", f48, 48'h8001_00_000000);
        chk("e24_ur_next", ur24, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
